// File: rtl/adc_sample_packer_pkg.sv
// Shared widths and the buffer entry type for the ADC sample packer.
package adc_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned WORD_W   = 64;
   localparam int unsigned LANES    = 4;

   // One buffered output beat: packed samples plus its end-of-frame tag.
   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic              last;
   } packed_word_t;

endpackage

// File: rtl/adc_sample_packer_fifo.sv
// First-word-fall-through buffer of packed words; accepts a write while full
// when a read happens on the same edge. Output reads as zero while empty.
module packer_fifo
   import adc_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  packed_word_t wr_data,
   input  logic         rd_en,
   output packed_word_t rd_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   packed_word_t  mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_rd;
   logic          do_wr;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are don't-care until the pointers expose them.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs 16-bit ADC samples into 64-bit AXI-Stream words with frame tlast,
// buffering and overflow accounting.
// Optional build macro ADC_PACKER_TEST_PATTERN_EN adds a test_mode input that
// replaces accepted samples with an incrementing 16-bit counter.
module adc_sample_packer
   import adc_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned FRAME_BEATS = 512
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                adc_valid,
   input  logic [SAMPLE_W-1:0] adc_data,
`ifdef ADC_PACKER_TEST_PATTERN_EN
   input  logic                test_mode,
`endif
   output logic [WORD_W-1:0]   m_axis_tdata,
   output logic [7:0]          m_axis_tkeep,
   output logic                m_axis_tlast,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                overflow,
   output logic [15:0]         drop_count
);

   localparam int unsigned LW = $clog2(LANES);

   logic [LW-1:0]              lane_q, lane_d;
   logic [WORD_W-SAMPLE_W-1:0] pack_q, pack_d;
   logic [15:0]                beat_q, beat_d;
   logic [15:0]                drop_q, drop_d;
   logic                       ovf_q, ovf_d;
   logic [SAMPLE_W-1:0]        sample;
   logic                       accept;
   logic                       word_done;
   logic                       pop;
   logic                       push_ok;
   logic                       drop;
   logic                       fifo_full;
   logic                       fifo_empty;
   packed_word_t               wr_word;
   packed_word_t               rd_word;

   assign accept = enable & adc_valid;

`ifdef ADC_PACKER_TEST_PATTERN_EN
   logic [SAMPLE_W-1:0] pat_q, pat_d;

   assign sample = test_mode ? pat_q : adc_data;

   // Test-pattern counter advances on every sample it replaces.
   always_comb begin
      pat_d = pat_q;
      if (accept && test_mode) pat_d = pat_q + 16'd1;
   end

   // Test-pattern counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) pat_q <= '0;
      else          pat_q <= pat_d;
   end
`else
   assign sample = adc_data;
`endif

   assign word_done = accept && (lane_q == LW'(LANES-1));
   assign pop       = m_axis_tvalid & m_axis_tready;
   assign push_ok   = word_done & (~fifo_full | pop);
   assign drop      = word_done & ~push_ok;

   // The final lane is never stored in pack_q: it goes straight into the word.
   assign wr_word.data = {sample, pack_q};
   assign wr_word.last = (beat_q == 16'(FRAME_BEATS-1));

   // Lane, packing, frame and drop accounting next-state.
   always_comb begin
      lane_d = lane_q;
      pack_d = pack_q;
      beat_d = beat_q;
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (!enable) begin
         lane_d = '0;
         pack_d = '0;
      end else if (adc_valid) begin
         lane_d = lane_q + LW'(1);
         case (lane_q)
            2'd0:    pack_d[15:0]  = sample;
            2'd1:    pack_d[31:16] = sample;
            2'd2:    pack_d[47:32] = sample;
            default: pack_d        = '0;
         endcase
      end
      if (push_ok) begin
         beat_d = (beat_q == 16'(FRAME_BEATS-1)) ? '0 : beat_q + 16'd1;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + 16'd1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lane_q <= '0;
         pack_q <= '0;
         beat_q <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         pack_q <= pack_d;
         beat_q <= beat_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   packer_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (push_ok),
      .wr_data (wr_word),
      .rd_en   (m_axis_tready),
      .rd_data (rd_word),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign m_axis_tdata  = rd_word.data;
   assign m_axis_tlast  = rd_word.last;
   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tkeep  = 8'hFF;
   assign overflow      = ovf_q;
   assign drop_count    = drop_q;

endmodule
